bus_xfer_arbiter: RTL and testbench

//  Parametrised, registered successor to the datapath source-select bus.

---
 rtl/bus_xfer_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_xfer_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_arbiter.sv
// Registered bus source select: direct index or round-robin arbitration onto one BUS_W word.
// Latency: 1 cycle from load request to bus_valid; back-to-back transfers at 1 word/cycle.
// Backpressure: word frozen while bus_valid & !bus_ready; a new load can replace it on the accepting edge.
module bus_xfer_arbiter #(
  parameter int NUM_SRC = 12,
  parameter int SEL_W   = 4,
  parameter int SRC_W   = 16,
  parameter int BUS_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     sel_valid,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*SRC_W-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_gnt,
  output logic [BUS_W-1:0]         bus_out,
  output logic [SEL_W-1:0]         bus_src,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic                     err_badsel,
  output logic [CNT_W-1:0]         xfer_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [SEL_W-1:0] src;
    logic [BUS_W-1:0] dat;
  } bus_word_t;

  // One extra bit so NUM_SRC == 2**SEL_W stays representable.
  localparam logic [SEL_W:0] NUM_SRC_X = (SEL_W+1)'(NUM_SRC);

  state_t           state;
  bus_word_t        word_q;
  bus_word_t        word_d;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_nxt;
  logic [SEL_W-1:0] winner;
  logic [SEL_W:0]   scan;
  logic [SEL_W:0]   wplus;
  logic             any_req;
  logic             load_ok;
  logic             sel_ok;
  logic             dir_load;
  logic             arb_load;
  logic             load;
  logic [SRC_W-1:0] slot [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    assign slot[g] = src_data[g*SRC_W +: SRC_W];
  end

  assign bus_valid = (state == HOLD);
  assign bus_out   = word_q.dat;
  assign bus_src   = word_q.src;
  assign load_ok   = !bus_valid || bus_ready;
  assign sel_ok    = {1'b0, sel} < NUM_SRC_X;

  // rr_ptr is always < NUM_SRC, so a single subtraction wraps the scan index.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    scan    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (scan >= NUM_SRC_X) scan = scan - NUM_SRC_X;
      if (!any_req && src_req[scan[SEL_W-1:0]]) begin
        any_req = 1'b1;
        winner  = scan[SEL_W-1:0];
      end
    end
  end

  assign dir_load = !mode && sel_valid && load_ok;
  assign arb_load = mode && any_req && load_ok;
  assign load     = dir_load || arb_load;
  assign wplus    = {1'b0, winner} + (SEL_W+1)'(1);
  assign rr_nxt   = (wplus == NUM_SRC_X) ? '0 : wplus[SEL_W-1:0];

  always_comb begin
    src_gnt = '0;
    if (arb_load) src_gnt[winner] = 1'b1;
  end

  // The size cast zero-extends narrow slots and truncates wide ones to the low bits.
  always_comb begin
    word_d.src = mode ? winner : sel;
    word_d.dat = '0;
    if (mode)        word_d.dat = BUS_W'(slot[winner]);
    else if (sel_ok) word_d.dat = BUS_W'(slot[sel]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_q     <= '0;
      err_badsel <= 1'b0;
      xfer_cnt   <= '0;
      rr_ptr     <= '0;
    end else begin
      err_badsel <= dir_load && !sel_ok;
      if (bus_valid && bus_ready) xfer_cnt <= xfer_cnt + CNT_W'(1);
      if (arb_load) rr_ptr <= rr_nxt;
      case (state)
        IDLE: begin
          if (load) begin
            word_q <= word_d;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (bus_ready) begin
            if (load) word_q <= word_d;
            else      state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Scoreboard bench for bus_xfer_arbiter: directed vectors push expected words, a negedge monitor pops on transfer.
module tb_bus_xfer_arbiter;

  localparam int NS = 12;
  localparam int SW = 4;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [15:0]   dat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel;
  logic           sel_valid;
  logic [NS-1:0]  src_req;
  logic [NS*16-1:0] src_data;
  logic [NS-1:0]  src_gnt;
  logic [15:0]    bus_out;
  logic [SW-1:0]  bus_src;
  logic           bus_valid;
  logic           bus_ready;
  logic           err_badsel;
  logic [15:0]    xfer_cnt;

  // Small instances for the width-fit checks
  logic           s_mode, s_sel, s_sel_valid, s_ready;
  logic [1:0]     s_req;
  logic [31:0]    n_data;
  logic [1:0]     n_gnt;
  logic [7:0]     n_out;
  logic           n_src, n_valid, n_err;
  logic [15:0]    n_cnt;
  logic [15:0]    w_data;
  logic [1:0]     w_gnt;
  logic [15:0]    w_out;
  logic           w_src, w_valid, w_err;
  logic [15:0]    w_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  bus_xfer_arbiter #(.NUM_SRC(NS), .SEL_W(SW), .SRC_W(16), .BUS_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .src_req(src_req), .src_data(src_data), .src_gnt(src_gnt), .bus_out(bus_out),
    .bus_src(bus_src), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .err_badsel(err_badsel), .xfer_cnt(xfer_cnt)
  );

  bus_xfer_arbiter #(.NUM_SRC(2), .SEL_W(1), .SRC_W(16), .BUS_W(8), .CNT_W(16)) u_nar (
    .clk(clk), .rst_n(rst_n), .mode(s_mode), .sel(s_sel), .sel_valid(s_sel_valid),
    .src_req(s_req), .src_data(n_data), .src_gnt(n_gnt), .bus_out(n_out),
    .bus_src(n_src), .bus_valid(n_valid), .bus_ready(s_ready),
    .err_badsel(n_err), .xfer_cnt(n_cnt)
  );

  bus_xfer_arbiter #(.NUM_SRC(2), .SEL_W(1), .SRC_W(8), .BUS_W(16), .CNT_W(16)) u_wid (
    .clk(clk), .rst_n(rst_n), .mode(s_mode), .sel(s_sel), .sel_valid(s_sel_valid),
    .src_req(s_req), .src_data(w_data), .src_gnt(w_gnt), .bus_out(w_out),
    .bus_src(w_src), .bus_valid(w_valid), .bus_ready(s_ready),
    .err_badsel(w_err), .xfer_cnt(w_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [15:0] v);
    src_data[i*16 +: 16] = v;
  endtask

  // A transfer completes on the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && bus_valid && bus_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got word 0x%0h src %0d, expected none", bus_out, bus_src);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_bus_out", 32'(bus_out), 32'(mon_e.dat));
        check("sb_bus_src", 32'(bus_src), 32'(mon_e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] g;
    int            alt [4];
    alt = '{3, 0, 3, 0};

    rst_n = 1'b0; mode = 1'b0; sel = '0; sel_valid = 1'b0; bus_ready = 1'b0;
    src_req = '0; src_data = '0;
    s_mode = 1'b0; s_sel = 1'b0; s_sel_valid = 1'b0; s_ready = 1'b0; s_req = '0;
    n_data = '0; w_data = '0;

    // Reset state
    #12;
    check("rst_valid", 32'(bus_valid), 0);
    check("rst_out",   32'(bus_out), 0);
    check("rst_src",   32'(bus_src), 0);
    check("rst_err",   32'(err_badsel), 0);
    check("rst_cnt",   32'(xfer_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(bus_valid), 0);

    // Direct select
    set_slot(5, 16'hABCD); sel = 4'd5; sel_valid = 1'b1; bus_ready = 1'b1;
    exp_q.push_back('{4'd5, 16'hABCD});
    tick();
    check("dir_valid", 32'(bus_valid), 1);
    check("dir_out",   32'(bus_out), 32'hABCD);
    sel_valid = 1'b0;
    tick();
    check("dir_cnt",   32'(xfer_cnt), 1);
    check("dir_idle",  32'(bus_valid), 0);

    // Back-pressure
    bus_ready = 1'b0; set_slot(3, 16'h1234); sel = 4'd3; sel_valid = 1'b1;
    exp_q.push_back('{4'd3, 16'h1234});
    tick();
    check("bp_valid", 32'(bus_valid), 1);
    for (int i = 0; i < 3; i++) begin
      sel = 4'(6 + i);
      set_slot(3, 16'h1111 * 16'(i + 1));
      set_slot(6 + i, 16'h2222 * 16'(i + 1));
      tick();
      check("bp_hold_out", 32'(bus_out), 32'h1234);
      check("bp_hold_src", 32'(bus_src), 3);
    end
    set_slot(7, 16'h5678); sel = 4'd7; bus_ready = 1'b1;
    exp_q.push_back('{4'd7, 16'h5678});
    tick();
    check("bp_cnt",  32'(xfer_cnt), 2);
    check("bp_new",  32'(bus_out), 32'h5678);
    check("bp_nsrc", 32'(bus_src), 7);
    sel_valid = 1'b0;
    tick();
    check("bp_cnt2", 32'(xfer_cnt), 3);

    // Bad select
    sel = 4'd13; sel_valid = 1'b1;
    exp_q.push_back('{4'd13, 16'h0000});
    tick();
    check("bad_err",   32'(err_badsel), 1);
    check("bad_valid", 32'(bus_valid), 1);
    check("bad_out",   32'(bus_out), 0);
    sel_valid = 1'b0;
    tick();
    check("bad_err_pulse", 32'(err_badsel), 0);
    check("bad_cnt",       32'(xfer_cnt), 4);

    // Round-robin over all requesters, then over sources 0 and 3
    for (int i = 0; i < NS; i++) set_slot(i, 16'hC000 + 16'(i));
    mode = 1'b1; src_req = 12'hFFF;
    for (int k = 0; k < 13; k++) begin
      exp_q.push_back('{4'(k % 12), 16'hC000 + 16'(k % 12)});
      #1;
      g = 12'd1 << (k % 12);
      check("rr_gnt", 32'(src_gnt), 32'(g));
      tick();
    end
    src_req = 12'h009; sel = 4'd13; sel_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{4'(alt[k]), 16'hC000 + 16'(alt[k])});
      #1;
      g = 12'd1 << alt[k];
      check("rr2_gnt", 32'(src_gnt), 32'(g));
      tick();
      check("rr2_noerr", 32'(err_badsel), 0);
    end
    src_req = '0; sel_valid = 1'b0;
    #1;
    check("rr_nogrant", 32'(src_gnt), 0);
    tick();
    check("rr_cnt",  32'(xfer_cnt), 21);
    check("rr_idle", 32'(bus_valid), 0);

    // Asynchronous reset while holding a word (word is discarded)
    mode = 1'b0; bus_ready = 1'b0; sel = 4'd2; set_slot(2, 16'h7777); sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    check("hold_valid", 32'(bus_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus_valid), 0);
    check("arst_out",   32'(bus_out), 0);
    check("arst_src",   32'(bus_src), 0);
    check("arst_cnt",   32'(xfer_cnt), 0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(bus_valid), 0);
    bus_ready = 1'b1;
    tick();
    check("post_rst_cnt", 32'(xfer_cnt), 0);

    // Width fit: truncate 16->8, zero-extend 8->16
    n_data = {16'hBEEF, 16'h0000}; w_data = {8'hA5, 8'h00};
    s_sel = 1'b1; s_sel_valid = 1'b1; s_ready = 1'b1;
    tick();
    check("fit_trunc", 32'(n_out), 32'hEF);
    check("fit_zext",  32'(w_out), 32'h00A5);
    check("fit_valid", 32'(n_valid), 1);
    s_sel_valid = 1'b0;
    tick();

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
